// File: rtl/uart_bridge_pkg.sv
// Shared state encoding and protocol byte values for the UART command bridge.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS,
        ST_REPLY
    } state_e;

    localparam logic [7:0] CMD_WRITE   = 8'h57;
    localparam logic [7:0] CMD_READ    = 8'h52;

    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_BADCMD  = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h45;

endpackage

// File: rtl/uart_cmd_bridge_timeout_counter.sv
// Saturating idle-cycle counter; expired_o flags the MAX-th consecutive enabled cycle.
module timeout_counter #(
    parameter int unsigned MAX = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (cnt_q == W'(MAX - 1));

endmodule

// File: rtl/uart_cmd_bridge.sv
// Parses 'W'/'R' byte frames from the UART RX path, runs one register-bus
// transaction per frame and returns a single reply byte to the UART TX path.
module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned FRAME_TIMEOUT = 1200000,
    parameter int unsigned BUS_TIMEOUT   = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    output logic       bus_req_o,
    output logic       bus_we_o,
    output logic [7:0] bus_addr_o,
    output logic [7:0] bus_wdata_o,
    input  logic [7:0] bus_rdata_i,
    input  logic       bus_ack_i,
    output logic       busy_o,
    output logic       overrun_o
);

    state_e     state_q, state_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       overrun_q, overrun_d;

    logic frame_en, frame_clear, frame_expired;
    logic bus_en, bus_clear, bus_expired;

    // Frame counter is held clear outside the byte-collecting states, which
    // also covers clearing on entry to GET_ADDR.
    assign frame_en    = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign frame_clear = !frame_en || rx_valid_i;
    assign bus_en      = (state_q == ST_BUS);
    assign bus_clear   = !bus_en;

    timeout_counter #(.MAX(FRAME_TIMEOUT)) u_frame_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (frame_clear),
        .enable_i (frame_en),
        .expired_o(frame_expired)
    );

    timeout_counter #(.MAX(BUS_TIMEOUT)) u_bus_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear_i  (bus_clear),
        .enable_i (bus_en),
        .expired_o(bus_expired)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_data_d = tx_data_q;
        overrun_d = overrun_q;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    if ((rx_data_i == CMD_WRITE) || (rx_data_i == CMD_READ)) begin
                        we_d    = (rx_data_i == CMD_WRITE);
                        state_d = ST_GET_ADDR;
                    end else begin
                        tx_data_d = RSP_BADCMD;
                        state_d   = ST_REPLY;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid_i) begin
                    addr_d  = rx_data_i;
                    state_d = we_q ? ST_GET_DATA : ST_BUS;
                end else if (frame_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (rx_valid_i) begin
                    wdata_d = rx_data_i;
                    state_d = ST_BUS;
                end else if (frame_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (rx_valid_i) begin
                    overrun_d = 1'b1;
                end
                if (bus_ack_i) begin
                    tx_data_d = we_q ? RSP_OK : bus_rdata_i;
                    state_d   = ST_REPLY;
                end else if (bus_expired) begin
                    tx_data_d = RSP_TIMEOUT;
                    state_d   = ST_REPLY;
                end
            end
            ST_REPLY: begin
                if (rx_valid_i) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = (state_q == ST_REPLY);
    assign bus_req_o   = (state_q == ST_BUS);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench for uart_cmd_bridge: directed and randomized frames
// compared against a frame-level reference model of replies and bus activity.
module tb_uart_cmd_bridge;
    import uart_bridge_pkg::*;

    localparam int FT = 100;
    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       bus_ack = 1'b0;
    logic       busy;
    logic       overrun;

    uart_cmd_bridge #(
        .FRAME_TIMEOUT(FT),
        .BUS_TIMEOUT  (BT)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .bus_req_o  (bus_req),
        .bus_we_o   (bus_we),
        .bus_addr_o (bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_rdata_i(bus_rdata),
        .bus_ack_i  (bus_ack),
        .busy_o     (busy),
        .overrun_o  (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Bus responder and observer: logs replies, counts request cycles and
    // acknowledges on the (ack_dly+1)-th request cycle of each transaction.
    logic [7:0] tx_log [0:255];
    int         tx_cyc_log [0:255];
    int         tx_n = 0;
    int         req_total = 0;
    int         frame_req_n = 0;
    logic       req_prev = 1'b0;
    logic       cap_we = 1'b0;
    logic [7:0] cap_addr = '0;
    logic [7:0] cap_wdata = '0;
    int         unstable = 0;
    int         ack_dly = 0;

    always @(negedge clk) begin
        req_prev <= bus_req;
        if (tx_valid) begin
            tx_log[tx_n[7:0]]     <= tx_data;
            tx_cyc_log[tx_n[7:0]] <= cyc;
            tx_n                  <= tx_n + 1;
        end
        if (bus_req) begin
            req_total   <= req_total + 1;
            frame_req_n <= req_prev ? frame_req_n + 1 : 1;
            bus_ack     <= ((req_prev ? frame_req_n : 0) == ack_dly);
            if (!req_prev) begin
                cap_we    <= bus_we;
                cap_addr  <= bus_addr;
                cap_wdata <= bus_wdata;
            end else if (bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata) begin
                unstable <= unstable + 1;
            end
        end else begin
            bus_ack <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int at);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        at       = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int tx0, input int budget, input string tag);
        int k = 0;
        while (tx_n <= tx0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, " reply-arrived"}, 32'(tx_n > tx0), 32'd1);
    endtask

    // addr_gap < 0 selects a random short gap before the address byte.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rdata, input int ack_delay, input bit inject,
                             input int addr_gap, input string tag);
        int lb, t, tx0, req0, unst0, exp_req, exp_lat;
        bit is_w, is_r, acked;
        logic [7:0] exp_rsp;
        bus_rdata = rdata;
        ack_dly   = ack_delay;
        tx0   = tx_n;
        req0  = req_total;
        unst0 = unstable;
        is_w  = (cmd == 8'h57);
        is_r  = (cmd == 8'h52);
        send_byte(cmd, $urandom_range(0, 3), lb);
        if (is_w || is_r) send_byte(addr, (addr_gap < 0) ? $urandom_range(0, 5) : addr_gap, lb);
        if (is_w) send_byte(wdata, $urandom_range(0, 5), lb);
        if (inject) send_byte(8'h57, 2, t);
        wait_tx(tx0, 60, tag);
        repeat (3) @(negedge clk);

        acked   = (is_w || is_r) && (ack_delay < BT);
        exp_req = !(is_w || is_r) ? 0 : (acked ? ack_delay + 1 : BT);
        exp_lat = !(is_w || is_r) ? 1 : exp_req + 1;
        if (!(is_w || is_r))  exp_rsp = 8'h3F;
        else if (!acked)      exp_rsp = 8'h45;
        else if (is_w)        exp_rsp = 8'h4B;
        else                  exp_rsp = rdata;

        check({tag, " reply-count"}, 32'(tx_n - tx0), 32'd1);
        check({tag, " reply-byte"}, 32'(tx_log[tx0[7:0]]), 32'(exp_rsp));
        check({tag, " reply-latency"}, 32'(tx_cyc_log[tx0[7:0]] - lb), 32'(exp_lat));
        check({tag, " tx_data-held"}, 32'(tx_data), 32'(exp_rsp));
        check({tag, " req-cycles"}, 32'(req_total - req0), 32'(exp_req));
        check({tag, " busy-after"}, 32'(busy), 32'd0);
        if (is_w || is_r) begin
            check({tag, " we"}, 32'(cap_we), 32'(is_w));
            check({tag, " addr"}, 32'(cap_addr), 32'(addr));
            if (is_w) check({tag, " wdata"}, 32'(cap_wdata), 32'(wdata));
            check({tag, " bus-stable"}, 32'(unstable - unst0), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lb, t, tx0, req0;
        logic [7:0] c;
        rst_n     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = '0;
        bus_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset tx_valid", 32'(tx_valid), 32'd0);
        check("reset tx_data", 32'(tx_data), 32'd0);
        check("reset bus_req", 32'(bus_req), 32'd0);
        check("reset bus_addr", 32'(bus_addr), 32'd0);
        check("reset bus_wdata", 32'(bus_wdata), 32'd0);
        check("reset busy/overrun", {30'd0, busy, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'h57, 8'h10, 8'hA5, 8'h00, 0, 1'b0, -1, "write-imm");
        run_frame(8'h52, 8'h22, 8'h00, 8'h3C, 5, 1'b0, -1, "read-ack5");
        run_frame(8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0, -1, "badcmd");
        run_frame(8'h52, 8'h31, 8'h00, 8'h9D, 15, 1'b0, -1, "ack-at-expiry");

        // Silence after the address byte abandons the frame.
        tx0  = tx_n;
        req0 = req_total;
        send_byte(8'h57, 0, lb);
        send_byte(8'h10, 0, lb);
        repeat (99) @(negedge clk);
        check("frame-to busy-before", 32'(busy), 32'd1);
        @(negedge clk);
        check("frame-to busy-after", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        check("frame-to no-reply", 32'(tx_n - tx0), 32'd0);
        check("frame-to no-req", 32'(req_total - req0), 32'd0);
        run_frame(8'h52, 8'h01, 8'h00, 8'h6E, 2, 1'b0, -1, "after-frame-to");

        // Address byte lands in the frame-timeout expiry cycle.
        run_frame(8'h57, 8'h44, 8'h19, 8'h00, 0, 1'b0, FT - 2, "byte-at-expiry");

        check("overrun pre-inject", 32'(overrun), 32'd0);
        run_frame(8'h52, 8'h77, 8'h00, 8'hC3, 1000, 1'b1, -1, "bus-timeout");
        check("overrun sticky", 32'(overrun), 32'd1);

        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 2))
                0:       c = 8'h57;
                1:       c = 8'h52;
                default: c = 8'($urandom_range(0, 255));
            endcase
            run_frame(c, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20),
                      1'b0, -1, "random");
        end

        // Asynchronous reset in the middle of a bus transaction.
        bus_rdata = 8'h55;
        ack_dly   = 1000;
        tx0       = tx_n;
        send_byte(8'h52, 0, lb);
        send_byte(8'h0F, 0, lb);
        repeat (2) @(negedge clk);
        check("mid-bus req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst tx_valid", 32'(tx_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst overrun", 32'(overrun), 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst no-reply", 32'(tx_n - tx0), 32'd0);
        run_frame(8'h57, 8'h5A, 8'hE1, 8'h00, 1, 1'b0, -1, "write-after-rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_cmd_bridge.md
Name: uart_cmd_bridge

Overview:
- Byte-protocol command decoder that sits directly downstream of the uart block's RX path and upstream of its TX path.
- Consumes received bytes (uart data_o/ready_o) and parses write/read frames.
- Issues single-beat 8-bit register-bus transactions.
- Emits one reply byte per frame into the uart TX input (data_i/ready_i).

Parameters:
- FRAME_TIMEOUT, 1200000, max idle clk_i cycles between bytes of one frame before the parser abandons it (100 ms at 12 MHz).
- BUS_TIMEOUT, 255, max clk_i cycles bus_req_o waits for bus_ack_i.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous, active-low reset
- rx_data_i  input  8  received byte; valid when rx_valid_i=1
- rx_valid_i  input  1  single-cycle strobe per received byte
- tx_data_o  output  8  reply byte
- tx_valid_o  output  1  single-cycle strobe; one per completed or rejected frame
- bus_req_o  output  1  register-bus request, held until ack or timeout
- bus_we_o  output  1  1=write, 0=read; stable while bus_req_o=1
- bus_addr_o  output  8  register address
- bus_wdata_o  output  8  write data
- bus_rdata_i  input  8  read data; valid with bus_ack_i
- bus_ack_i  input  1  transaction complete
- busy_o  output  1  1 in any state other than IDLE
- overrun_o  output  1  sticky; set when a byte is dropped; cleared only by reset

Behaviour:
- Reset, asynchronous: state IDLE, counters 0, all outputs 0 including tx_data_o, bus_addr_o and bus_wdata_o. Reset mid-frame or mid-transaction aborts with no reply.
- Frames:
  - Write: 0x57 ('W'), addr, data. Reply 0x4B ('K').
  - Read: 0x52 ('R'), addr. Reply = read data.
  - Any other first byte: reply 0x3F ('?').
  - Bus timeout: reply 0x45 ('E').
- FSM states: IDLE, GET_ADDR, GET_DATA, BUS, REPLY.
  - IDLE + rx_valid_i:
    - 'W' or 'R' -> GET_ADDR; latch we.
    - Else -> REPLY with '?'.
  - GET_ADDR + rx_valid_i: latch bus_addr_o.
    - we=1 -> GET_DATA.
    - we=0 -> BUS.
  - GET_DATA + rx_valid_i: latch bus_wdata_o -> BUS.
  - BUS:
    - bus_req_o=1 starting the first BUS cycle, i.e. the cycle after the final byte.
    - bus_ack_i sampled every BUS cycle, including the first.
    - On ack: req drops next cycle; capture rdata on reads -> REPLY.
    - No ack after BUS_TIMEOUT BUS cycles -> REPLY with 'E'. Ack in the expiry cycle wins over timeout.
  - REPLY: tx_valid_o=1 for exactly one cycle with tx_data_o -> IDLE. tx_data_o holds its value after the strobe.
- Latency:
  - Write with immediate ack: final byte at cycle N -> req at N+1 -> tx_valid_o at N+2.
  - Unknown command: byte at N -> tx_valid_o at N+1.
- Inter-byte timeout:
  - Shared counter, active in GET_ADDR and GET_DATA; cleared on every accepted byte and on state entry.
  - Reaching FRAME_TIMEOUT-1 with no byte -> IDLE, no reply, no bus access.
  - A byte in the expiry cycle is accepted; it takes priority over the timeout.
- Drops: rx_valid_i in BUS or REPLY drops the byte and sets overrun_o; no other effect.
- No TX backpressure; the host must await each reply before sending the next frame.
- Counter widths: $clog2(param+1). Counters saturate and never wrap.

Decomposition:
- Package uart_bridge_pkg:
  - state_e enum.
  - CMD_WRITE=8'h57, CMD_READ=8'h52.
  - RSP_OK=8'h4B, RSP_BADCMD=8'h3F, RSP_TIMEOUT=8'h45.
- One natural sub-module: timeout_counter.
  - Parameter MAX.
  - Inputs: clear_i, enable_i.
  - Output: expired_o.
  - Instantiated twice, for frame timeout and bus timeout.

Test Plan (bench: FRAME_TIMEOUT=100, BUS_TIMEOUT=16):
- Write 0x57,0x10,0xA5 with ack on the first req cycle -> one bus write (addr=0x10, wdata=0xA5, we=1, req high 1 cycle); tx_valid_o pulse with 0x4B 2 cycles after the last byte.
- Read 0x52,0x22 with bus_rdata_i=0x3C, ack after 5 cycles -> req high 6 cycles, we=0, addr=0x22; reply 0x3C.
- Byte 0x00 in IDLE -> no bus activity; reply 0x3F next cycle.
- 0x57,0x10 then silence for 100 cycles -> busy_o drops, no reply, no req. A following 0x52,0x01 frame completes normally.
- Read with ack never asserted -> req high exactly 16 cycles, then reply 0x45. A byte injected during BUS sets overrun_o=1 and does not change the reply.
- Reset asserted mid-BUS -> bus_req_o, tx_valid_o, busy_o and overrun_o go 0 immediately. After release, a write frame works.
